reg_file_writeback: RTL and testbench



---
 rtl/reg_file_writeback.sv | 112 +++++++++++
 tb/tb_reg_file_writeback.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_writeback.sv
// Writeback register bank: 64 x 32 register file with a same-cycle write-to-read
// bypass and a pending-write scoreboard that tells decode when to stall.
module reg_file_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Reg_Write,
    input  logic [ADDR_WIDTH-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2,
    input  logic                  Read_Valid,
    input  logic                  Issue_Valid,
    input  logic [ADDR_WIDTH-1:0] Issue_Register,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2,
    output logic                  Stall,
    output logic [ADDR_WIDTH:0]   Pending_Count
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic [NUM_REGS-1:0]   write_hit;
    logic [NUM_REGS-1:0]   issue_hit;
    logic [ADDR_WIDTH:0]   count_next;

    logic                  clear_1;
    logic                  clear_2;
    logic                  pend_1;
    logic                  pend_2;

    // One-hot decode of the write and issue ports; slot 0 is never selected.
    always_comb begin
        write_hit = '0;
        issue_hit = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            write_hit[i] = Reg_Write   && (Write_Register == ADDR_WIDTH'(i));
            issue_hit[i] = Issue_Valid && (Issue_Register == ADDR_WIDTH'(i));
        end
    end

    // Set after clear: a producer issued in the same cycle as a writeback to the
    // same register owns the register from now on.
    always_comb begin
        pending_next = (pending & ~write_hit) | issue_hit;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + (ADDR_WIDTH + 1)'(pending_next[i]);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (write_hit[i]) begin
                    regs[i] <= Write_Data;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending       <= '0;
            Pending_Count <= '0;
        end else begin
            pending       <= pending_next;
            Pending_Count <= count_next;
        end
    end

    always_comb begin
        if (Read_Register_1 == '0) begin
            Read_Data_1 = '0;
        end else if (Reg_Write && (Write_Register == Read_Register_1)) begin
            Read_Data_1 = Write_Data;
        end else begin
            Read_Data_1 = regs[Read_Register_1];
        end
    end

    always_comb begin
        if (Read_Register_2 == '0) begin
            Read_Data_2 = '0;
        end else if (Reg_Write && (Write_Register == Read_Register_2)) begin
            Read_Data_2 = Write_Data;
        end else begin
            Read_Data_2 = regs[Read_Register_2];
        end
    end

    // A same-cycle writeback to a source resolves its hazard through the bypass.
    always_comb begin
        clear_1 = Reg_Write && (Write_Register == Read_Register_1);
        clear_2 = Reg_Write && (Write_Register == Read_Register_2);
        pend_1  = (Read_Register_1 != '0) && pending[Read_Register_1];
        pend_2  = (Read_Register_2 != '0) && pending[Read_Register_2];
        Stall   = Read_Valid && ((pend_1 && !clear_1) || (pend_2 && !clear_2));
    end

endmodule

// File: tb/tb_reg_file_writeback.sv
// Scoreboard bench for reg_file_writeback: directed scenarios followed by
// randomized traffic, checked against an array-based reference model.
module tb_reg_file_writeback;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Reg_Write;
    logic [5:0]  Write_Register;
    logic [31:0] Write_Data;
    logic [5:0]  Read_Register_1;
    logic [5:0]  Read_Register_2;
    logic        Read_Valid;
    logic        Issue_Valid;
    logic [5:0]  Issue_Register;
    logic [31:0] Read_Data_1;
    logic [31:0] Read_Data_2;
    logic        Stall;
    logic [6:0]  Pending_Count;

    reg_file_writeback dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Reg_Write       (Reg_Write),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data),
        .Read_Register_1 (Read_Register_1),
        .Read_Register_2 (Read_Register_2),
        .Read_Valid      (Read_Valid),
        .Issue_Valid     (Issue_Valid),
        .Issue_Register  (Issue_Register),
        .Read_Data_1     (Read_Data_1),
        .Read_Data_2     (Read_Data_2),
        .Stall           (Stall),
        .Pending_Count   (Pending_Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic [6:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [31:0] m_mem  [64];
    bit          m_pend [64];

    function automatic int model_count();
        int s = 0;
        foreach (m_pend[i]) s += int'(m_pend[i]);
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] idx, input logic we,
                                               input logic [5:0] wr, input logic [31:0] wd);
        if (idx == 6'd0) return 32'd0;
        if (we && wr == idx) return wd;
        return m_mem[idx];
    endfunction

    function automatic logic model_busy(input logic [5:0] idx, input logic we, input logic [5:0] wr);
        if (idx == 6'd0) return 1'b0;
        return m_pend[idx] && !(we && wr == idx);
    endfunction

    // One clock of stimulus: drive, push the expected outputs, then advance the model.
    task automatic drive_cycle(input logic rst, input logic we, input logic [5:0] wr,
                               input logic [31:0] wd, input logic [5:0] r1, input logic [5:0] r2,
                               input logic rv, input logic iv, input logic [5:0] ir);
        exp_t e;
        @(posedge Clock);
        #1;
        cyc++;
        Reset = rst; Reg_Write = we; Write_Register = wr; Write_Data = wd;
        Read_Register_1 = r1; Read_Register_2 = r2; Read_Valid = rv;
        Issue_Valid = iv; Issue_Register = ir;
        e.cyc   = cyc;
        e.rd1   = model_read(r1, we, wr, wd);
        e.rd2   = model_read(r2, we, wr, wd);
        e.stall = rv && (model_busy(r1, we, wr) || model_busy(r2, we, wr));
        e.cnt   = 7'(model_count());
        exp_q.push_back(e);
        if (rst) begin
            foreach (m_mem[i]) begin
                m_mem[i]  = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wr != 6'd0) begin
                m_mem[wr]  = wd;
                m_pend[wr] = 1'b0;
            end
            if (iv && ir != 6'd0) m_pend[ir] = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (Read_Data_1 !== e.rd1) begin
                    n_err++;
                    $display("FAIL rd1 cyc=%0d got=%h exp=%h", e.cyc, Read_Data_1, e.rd1);
                end
                n_vec++;
                if (Read_Data_2 !== e.rd2) begin
                    n_err++;
                    $display("FAIL rd2 cyc=%0d got=%h exp=%h", e.cyc, Read_Data_2, e.rd2);
                end
                n_vec++;
                if (Stall !== e.stall) begin
                    n_err++;
                    $display("FAIL stall cyc=%0d got=%b exp=%b", e.cyc, Stall, e.stall);
                end
                n_vec++;
                if (Pending_Count !== e.cnt) begin
                    n_err++;
                    $display("FAIL pending_count cyc=%0d got=%0d exp=%0d", e.cyc, Pending_Count, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5:0]  wr, r1, r2, ir;
        logic        we, iv, rv, rst;
        int          wait_cycles;

        Reset = 1'b1; Reg_Write = 1'b0; Write_Register = '0; Write_Data = '0;
        Read_Register_1 = '0; Read_Register_2 = '0; Read_Valid = 1'b0;
        Issue_Valid = 1'b0; Issue_Register = '0;
        foreach (m_mem[i]) begin
            m_mem[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
        @(posedge Clock);

        // rst, we, wr, wd, r1, r2, rv, iv, ir
        drive_cycle(1, 0, 0,  32'h0,        5,  63, 1, 0, 0);
        drive_cycle(0, 1, 12, 32'hDEADBEEF, 12, 12, 0, 0, 0);
        drive_cycle(0, 0, 0,  32'h0,        12, 12, 1, 0, 0);
        drive_cycle(0, 1, 0,  32'h1234,     0,  0,  1, 1, 0);
        drive_cycle(0, 0, 0,  32'h0,        0,  0,  1, 0, 0);
        drive_cycle(0, 0, 0,  32'h0,        1,  2,  0, 1, 7);
        drive_cycle(0, 0, 0,  32'h0,        1,  7,  1, 0, 0);
        drive_cycle(0, 1, 7,  32'h55,       1,  7,  1, 0, 0);
        drive_cycle(0, 0, 0,  32'h0,        7,  7,  1, 0, 0);
        drive_cycle(0, 1, 9,  32'hA5,       1,  2,  0, 1, 9);
        drive_cycle(0, 0, 0,  32'h0,        9,  1,  1, 0, 0);
        drive_cycle(0, 1, 9,  32'hA5,       1,  2,  0, 1, 3);
        drive_cycle(0, 0, 0,  32'h0,        1,  2,  0, 1, 4);
        drive_cycle(0, 0, 0,  32'h0,        1,  2,  0, 1, 5);
        drive_cycle(1, 1, 3,  32'hFF,       3,  4,  1, 0, 0);
        drive_cycle(0, 0, 0,  32'h0,        3,  4,  1, 0, 0);
        drive_cycle(0, 0, 0,  32'h0,        5,  3,  1, 0, 0);

        // Random traffic, mostly on a narrow index window so hazards and bypasses collide.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr = 6'($urandom_range(0, 63)); r1 = 6'($urandom_range(0, 63));
                r2 = 6'($urandom_range(0, 63)); ir = 6'($urandom_range(0, 63));
            end else begin
                wr = 6'($urandom_range(0, 7)); r1 = 6'($urandom_range(0, 7));
                r2 = 6'($urandom_range(0, 7)); ir = 6'($urandom_range(0, 7));
            end
            we  = ($urandom_range(0, 1) == 1);
            iv  = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            drive_cycle(rst, we, wr, $urandom, r1, r2, rv, iv, ir);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge Clock);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
